axis_frame_gen: RTL and testbench

AXI-Stream frame source that drives the s_axis slave port of the stream FIFO and other AXIS sinks in the datapath. It emits a programmable number of frames, each of programmable length. Payload is a deterministic incrementing pattern, and TLAST marks the final beat of each frame. Primary uses are in-system traffic generation and FIFO loopback bring-up.

---
 rtl/axis_frame_gen.sv | 162 ++++++++++++++++
 tb/tb_axis_frame_gen.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/axis_frame_gen.sv
// AXI-Stream traffic source: emits runs of fixed-length frames carrying an incrementing
// data pattern, with optional idle gaps between frames and a graceful stop at frame boundaries.
module axis_frame_gen #(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 12,
    parameter int GAP_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  stop,
    input  logic [LEN_WIDTH-1:0]  cfg_len,
    input  logic [7:0]            cfg_frames,
    input  logic [GAP_WIDTH-1:0]  cfg_gap,
    input  logic [DATA_WIDTH-1:0] cfg_seed,
    output logic [DATA_WIDTH-1:0] m_axis_data,
    output logic                  m_axis_valid,
    input  logic                  m_axis_ready,
    output logic                  m_axis_last,
    output logic                  busy,
    output logic                  done,
    output logic [15:0]           frame_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP, S_END} state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [LEN_WIDTH-1:0]  beat_q, beat_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [7:0]            frames_q, frames_d;
    logic [GAP_WIDTH-1:0]  gap_cfg_q, gap_cfg_d;
    logic [GAP_WIDTH-1:0]  gap_cnt_q, gap_cnt_d;
    logic [15:0]           frame_cnt_q, frame_cnt_d;
    logic                  stop_q, stop_d;
    logic                  valid_q, valid_d;
    logic                  last_q, last_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic accept;
    logic xfer;
    logic run_end;

    assign accept  = start && (cfg_len != '0);
    assign xfer    = valid_q && m_axis_ready;
    // A stop seen in the same cycle as the closing beat still ends the run there.
    assign run_end = ((frames_q != 8'd0) && ((frame_cnt_q + 16'd1) == {8'd0, frames_q}))
                     || stop_q || stop;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept) state_d = S_SEND;
            S_SEND: begin
                if (xfer && last_q) begin
                    if (run_end)               state_d = S_END;
                    else if (gap_cfg_q != '0)  state_d = S_GAP;
                    else                       state_d = S_SEND;
                end
            end
            S_GAP: begin
                if (stop)                    state_d = S_END;
                else if (gap_cnt_q == '0)    state_d = S_SEND;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        data_d      = data_q;
        beat_d      = beat_q;
        len_d       = len_q;
        frames_d    = frames_q;
        gap_cfg_d   = gap_cfg_q;
        gap_cnt_d   = gap_cnt_q;
        frame_cnt_d = frame_cnt_q;
        stop_d      = stop_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    len_d       = cfg_len;
                    frames_d    = cfg_frames;
                    gap_cfg_d   = cfg_gap;
                    data_d      = cfg_seed;
                    beat_d      = LEN_WIDTH'(1);
                    frame_cnt_d = '0;
                    stop_d      = 1'b0;
                end
            end
            S_SEND: begin
                if (stop) stop_d = 1'b1;
                if (xfer) begin
                    data_d = data_q + DATA_WIDTH'(1);
                    if (last_q) begin
                        frame_cnt_d = frame_cnt_q + 16'd1;
                        beat_d      = LEN_WIDTH'(1);
                        gap_cnt_d   = gap_cfg_q - GAP_WIDTH'(1);
                    end else begin
                        beat_d = beat_q + LEN_WIDTH'(1);
                    end
                end
            end
            S_GAP: begin
                if (stop) stop_d = 1'b1;
                gap_cnt_d = gap_cnt_q - GAP_WIDTH'(1);
            end
            default: ;
        endcase
        // Stream and status outputs are registered from the upcoming state.
        valid_d = (state_d == S_SEND);
        last_d  = (state_d == S_SEND) && (beat_d == len_d);
        busy_d  = (state_d == S_SEND) || (state_d == S_GAP);
        done_d  = (state_d == S_END);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q      <= '0;
            beat_q      <= '0;
            len_q       <= '0;
            frames_q    <= '0;
            gap_cfg_q   <= '0;
            gap_cnt_q   <= '0;
            frame_cnt_q <= '0;
            stop_q      <= 1'b0;
            valid_q     <= 1'b0;
            last_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            data_q      <= data_d;
            beat_q      <= beat_d;
            len_q       <= len_d;
            frames_q    <= frames_d;
            gap_cfg_q   <= gap_cfg_d;
            gap_cnt_q   <= gap_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            stop_q      <= stop_d;
            valid_q     <= valid_d;
            last_q      <= last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign m_axis_data  = data_q;
    assign m_axis_valid = valid_q;
    assign m_axis_last  = last_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign frame_cnt    = frame_cnt_q;

endmodule

// File: tb/tb_axis_frame_gen.sv
// Randomised bench for axis_frame_gen: a cycle-level model built from the frame/gap/stop
// rules predicts every output; inputs are driven #1 after posedge and outputs sampled at negedge.
module tb_axis_frame_gen;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        stop;
    logic [11:0] cfg_len;
    logic [7:0]  cfg_frames;
    logic [7:0]  cfg_gap;
    logic [31:0] cfg_seed;
    logic [31:0] m_axis_data;
    logic        m_axis_valid;
    logic        m_axis_ready;
    logic        m_axis_last;
    logic        busy;
    logic        done;
    logic [15:0] frame_cnt;

    axis_frame_gen #(.DATA_WIDTH(32), .LEN_WIDTH(12), .GAP_WIDTH(8)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .stop         (stop),
        .cfg_len      (cfg_len),
        .cfg_frames   (cfg_frames),
        .cfg_gap      (cfg_gap),
        .cfg_seed     (cfg_seed),
        .m_axis_data  (m_axis_data),
        .m_axis_valid (m_axis_valid),
        .m_axis_ready (m_axis_ready),
        .m_axis_last  (m_axis_last),
        .busy         (busy),
        .done         (done),
        .frame_cnt    (frame_cnt)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Model state: phase 0 idle, 1 beat expected, 2 gap cycle, 3 done cycle.
    int          phase = 0;
    int          k = 0;
    int          frames_done = 0;
    int          gap_left = 0;
    bit          stop_seen = 0;
    int          m_len = 1;
    int          m_frames = 0;
    int          m_gap = 0;
    logic [31:0] m_seed = '0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (k=%0d t=%0t)", tag, got, exp, k, $time);
        end
    endtask

    task automatic evaluate;
        logic [31:0] exp_data;
        bit          exp_last;
        case (phase)
            0: begin
                check_eq("idle_valid", m_axis_valid, 0);
                check_eq("idle_busy", busy, 0);
                check_eq("idle_done", done, 0);
                check_eq("idle_frame_cnt", frame_cnt, 16'(frames_done));
            end
            1: begin
                exp_data = m_seed + 32'(k);
                exp_last = ((k % m_len) == (m_len - 1));
                check_eq("send_valid", m_axis_valid, 1);
                check_eq("send_busy", busy, 1);
                check_eq("send_done", done, 0);
                check_eq("send_data", m_axis_data, exp_data);
                check_eq("send_last", m_axis_last, exp_last);
                check_eq("send_frame_cnt", frame_cnt, 16'(frames_done));
                if (stop) stop_seen = 1;
                if (m_axis_ready) begin
                    k++;
                    if (exp_last) begin
                        frames_done++;
                        if ((m_frames != 0 && frames_done == m_frames) || stop_seen) begin
                            phase = 3;
                        end else if (m_gap != 0) begin
                            phase = 2;
                            gap_left = m_gap;
                        end
                    end
                end
            end
            2: begin
                check_eq("gap_valid", m_axis_valid, 0);
                check_eq("gap_busy", busy, 1);
                check_eq("gap_frame_cnt", frame_cnt, 16'(frames_done));
                gap_left--;
                if (gap_left == 0) phase = 1;
            end
            default: begin
                check_eq("end_done", done, 1);
                check_eq("end_valid", m_axis_valid, 0);
                check_eq("end_busy", busy, 0);
                check_eq("end_frame_cnt", frame_cnt, 16'(frames_done));
                phase = 0;
            end
        endcase
    endtask

    task automatic run_case(input int len, input int frames, input int gap,
                            input logic [31:0] seed, input int pct, input int stop_k);
        int cyc;
        bit stop_used;
        @(posedge clk); #1;
        cfg_len      = 12'(len);
        cfg_frames   = 8'(frames);
        cfg_gap      = 8'(gap);
        cfg_seed     = seed;
        start        = 1'b1;
        stop         = 1'b0;
        m_axis_ready = 1'b1;
        @(negedge clk);
        evaluate();
        if (len != 0) begin
            phase = 1; m_len = len; m_frames = frames; m_gap = gap; m_seed = seed;
            k = 0; frames_done = 0; stop_seen = 0;
        end
        stop_used = 0;
        cyc = 0;
        while (phase != 0 && cyc < 2000) begin
            @(posedge clk); #1;
            m_axis_ready = ($urandom_range(1, 100) <= pct);
            stop = 1'b0;
            if (phase == 1 && !stop_used && stop_k >= 0 && k == stop_k) begin
                stop = 1'b1;
                stop_used = 1;
            end
            // Start pulses and config churn while busy must be ignored.
            if (phase == 1 || phase == 2) begin
                start      = 1'($urandom_range(0, 1));
                cfg_len    = 12'($urandom_range(0, 9));
                cfg_frames = 8'($urandom);
                cfg_gap    = 8'($urandom_range(0, 5));
                cfg_seed   = $urandom;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            evaluate();
            cyc++;
        end
        if (phase != 0) begin
            check_eq("run_timeout", 1, 0);
            reset_n = 1'b0;
            #1 reset_n = 1'b1;
            phase = 0;
            frames_done = 0;
        end
        repeat (3) begin
            @(posedge clk); #1;
            start = 1'b0;
            stop = 1'b0;
            m_axis_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            evaluate();
        end
        $display("run len=%0d frames=%0d gap=%0d seed=%08h ready%%=%0d stop_k=%0d -> beats=%0d frames=%0d",
                 len, frames, gap, seed, pct, stop_k, k, frames_done);
    endtask

    initial begin
        int          len, frames, gap, pct, sk;
        logic [31:0] seed;
        reset_n = 1'b0; start = 1'b0; stop = 1'b0; m_axis_ready = 1'b0;
        cfg_len = '0; cfg_frames = '0; cfg_gap = '0; cfg_seed = '0;
        #12;
        check_eq("rst_valid", m_axis_valid, 0);
        check_eq("rst_last", m_axis_last, 0);
        check_eq("rst_data", m_axis_data, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_frame_cnt", frame_cnt, 0);
        @(negedge clk);
        reset_n = 1'b1;

        run_case(4, 2, 0, 32'h10, 100, -1);
        run_case(4, 2, 3, 32'h10, 100, -1);
        run_case(3, 1, 0, 32'h55, 50, -1);
        run_case(5, 0, 0, 32'h100, 100, 11);
        run_case(4, 1, 0, 32'hFFFF_FFFE, 100, -1);

        // Reset in the middle of a continuous run abandons the frame at once.
        @(posedge clk); #1;
        cfg_len = 12'd2; cfg_frames = 8'd0; cfg_gap = 8'd0; cfg_seed = 32'hA0;
        start = 1'b1; m_axis_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        check_eq("pre_rst_valid", m_axis_valid, 1);
        check_eq("pre_rst_data", m_axis_data, 32'hA6);
        check_eq("pre_rst_frame_cnt", frame_cnt, 3);
        #1 reset_n = 1'b0;
        #1;
        check_eq("mid_rst_valid", m_axis_valid, 0);
        check_eq("mid_rst_last", m_axis_last, 0);
        check_eq("mid_rst_busy", busy, 0);
        check_eq("mid_rst_frame_cnt", frame_cnt, 0);
        @(negedge clk);
        reset_n = 1'b1;
        phase = 0;
        frames_done = 0;

        run_case(0, 2, 0, 32'h33, 100, -1);

        for (int r = 0; r < 14; r++) begin
            len    = int'($urandom_range(1, 6));
            frames = int'($urandom_range(0, 3));
            gap    = int'($urandom_range(0, 3));
            pct    = int'($urandom_range(30, 100));
            seed   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF8 + 32'($urandom_range(0, 7))) : $urandom;
            if (frames == 0)                  sk = int'($urandom_range(0, 20));
            else if ($urandom_range(0, 1) == 1) sk = int'($urandom_range(0, len * frames - 1));
            else                              sk = -1;
            run_case(len, frames, gap, seed, pct, sk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
